// File: rtl/interrupt_ctrl_pkg.sv
// Shared processor definitions for the interrupt controller: FSM states and redirect vector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package interrupt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Fetch-stage redirect target when interrupt is asserted.
    localparam logic [31:0] IRQ_VECTOR = 32'h0000_0004;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index of req wins.
// Latency: combinational.
// Backpressure: none; result follows req in the same cycle.
module irq_prio_enc #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req,
    output logic                       vld,
    output logic [$clog2(NUM_SRC)-1:0] idx
);

    localparam int ID_W = $clog2(NUM_SRC);

    // Scan from the top down so the lowest requesting index is the last one written.
    always_comb begin
        vld = |req;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_ctrl.sv
// Edge-triggered, non-nesting interrupt controller driving a fetch-stage redirect.
// Latency: source edge -> pending +1 cycle -> interrupt +2 cycles (no stall).
// Backpressure: stall holds interrupt high until accepted; optional watchdog (IRQ_TIMEOUT_EN) bounds SERVICE.
module interrupt_ctrl
    import interrupt_ctrl_pkg::*;
#(
    parameter int NUM_SRC        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         irq_src,
    input  logic [NUM_SRC-1:0]         irq_mask,
    input  logic                       stall,
    input  logic                       rti,
    input  logic                       rsi,
    output logic                       interrupt,
    output logic [$clog2(NUM_SRC)-1:0] irq_id,
    output logic                       in_service,
    output logic [NUM_SRC-1:0]         pending,
    output logic                       timeout_err
);

    localparam int ID_W = $clog2(NUM_SRC);

    irq_state_t         state;
    logic [NUM_SRC-1:0] prev_src;
    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] clr_mask;
    logic               sel_vld;
    logic [ID_W-1:0]    sel_idx;
    logic               done;
    logic               timeout_hit;

    // rti and rsi both end the handler; the saved-PC difference lives in the fetch stage.
    assign done     = rti | rsi;
    assign src_edge = irq_src & ~prev_src;
    assign eligible = pending & irq_mask;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio (
        .req (eligible),
        .vld (sel_vld),
        .idx (sel_idx)
    );

    // Only the source being dispatched out of IDLE has its pending bit consumed.
    always_comb begin
        clr_mask = '0;
        if (state == IDLE && sel_vld) begin
            clr_mask[sel_idx] = 1'b1;
        end
    end

    // Edge capture: a fresh edge wins over a same-cycle clear so it is never lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_src <= '0;
            pending  <= '0;
        end else begin
            prev_src <= irq_src;
            pending  <= (pending & ~clr_mask) | src_edge;
        end
    end

    // Dispatch FSM with registered interrupt / in_service; irq_id only moves on FIRE entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            interrupt  <= 1'b0;
            in_service <= 1'b0;
            irq_id     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        state     <= FIRE;
                        irq_id    <= sel_idx;
                        interrupt <= 1'b1;
                    end
                end
                FIRE: begin
                    if (!stall) begin
                        state      <= SERVICE;
                        interrupt  <= 1'b0;
                        in_service <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (done || timeout_hit) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    interrupt  <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

`ifdef IRQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] watchdog;

    assign timeout_hit = (state == SERVICE) && !done &&
                         (watchdog == WD_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive SERVICE cycles; cleared whenever the handler is not running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            watchdog <= '0;
        end else if (state == SERVICE && !done && !timeout_hit) begin
            watchdog <= watchdog + 1'b1;
        end else begin
            watchdog <= '0;
        end
    end

    // Sticky error: only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Configuration constants not consumed by logic in every build.
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0) ^ IRQ_VECTOR[2];

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Bench for interrupt_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Latency: n/a.
// Backpressure: stall is driven randomly and in a directed burst.
module tb_interrupt_ctrl;

    localparam int N = 4;
`ifdef IRQ_TIMEOUT_EN
    localparam int  TO     = 16;
    localparam bit  TO_ON  = 1'b1;
`else
    localparam int  TO     = 1024;
    localparam bit  TO_ON  = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] irq_src;
    logic [N-1:0] irq_mask;
    logic         stall;
    logic         rti;
    logic         rsi;
    logic         interrupt;
    logic [1:0]   irq_id;
    logic         in_service;
    logic [N-1:0] pending;
    logic         timeout_err;

    interrupt_ctrl #(
        .NUM_SRC        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq_src     (irq_src),
        .irq_mask    (irq_mask),
        .stall       (stall),
        .rti         (rti),
        .rsi         (rsi),
        .interrupt   (interrupt),
        .irq_id      (irq_id),
        .in_service  (in_service),
        .pending     (pending),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = waiting, 1 = requesting redirect, 2 = handler running.
    bit [N-1:0] m_pend, m_prev, m_edges, m_clr;
    int         m_mode, m_id, m_cnt;
    bit         m_terr, m_found;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pend = '0; m_prev = '0; m_mode = 0; m_id = 0; m_cnt = 0; m_terr = 1'b0;
        end else begin
            m_edges = irq_src & ~m_prev;
            m_clr   = '0;
            if (m_mode == 0) begin
                m_found = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (!m_found && m_pend[i] && irq_mask[i]) begin
                        m_found = 1'b1;
                        m_id    = i;
                    end
                end
                if (m_found) begin
                    m_mode     = 1;
                    m_clr[m_id] = 1'b1;
                end
            end else if (m_mode == 1) begin
                if (!stall) begin
                    m_mode = 2;
                    m_cnt  = 0;
                end
            end else begin
                if (rti || rsi) begin
                    m_mode = 0;
                end else if (TO_ON) begin
                    m_cnt++;
                    if (m_cnt == TO) begin
                        m_mode = 0;
                        m_terr = 1'b1;
                    end
                end
            end
            m_pend = (m_pend & ~m_clr) | m_edges;
            m_prev = irq_src;
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_interrupt",  interrupt,   (m_mode == 1) ? 1 : 0);
            check("m_in_service", in_service,  (m_mode == 2) ? 1 : 0);
            check("m_irq_id",     irq_id,      m_id);
            check("m_pending",    pending,     m_pend);
            check("m_timeout",    timeout_err, m_terr);
        end
    end

    task automatic nxt();
        @(negedge clk);
    endtask

    int hi;
    int n;

    initial begin
        rst_n = 1'b0; irq_src = '0; irq_mask = 4'hF; stall = 1'b0; rti = 1'b0; rsi = 1'b0;
        nxt(); nxt();
        chk_en = 1'b1;
        check("rst_interrupt", interrupt, 0);
        check("rst_in_service", in_service, 0);
        check("rst_pending", pending, 0);
        check("rst_irq_id", irq_id, 0);
        check("rst_timeout", timeout_err, 0);
        rst_n = 1'b1;
        nxt();

        // Single source, minimum latency.
        irq_src = 4'b0001;
        nxt(); check("lat_pending", pending, 4'b0001); check("lat_int_early", interrupt, 0);
        nxt(); check("lat_interrupt", interrupt, 1); check("lat_id", irq_id, 0); check("lat_pend_clr", pending, 0);
        nxt(); check("lat_in_service", in_service, 1); check("lat_int_drop", interrupt, 0);
        rsi = 1'b1; nxt(); rsi = 1'b0;
        check("rsi_idle", in_service, 0);
        irq_src = '0; nxt();

        // Simultaneous edges: lowest index first, then the other after rsi.
        irq_src = 4'b0110;
        nxt(); check("sim_pending", pending, 4'b0110);
        nxt(); check("sim_id1", irq_id, 1); check("sim_int1", interrupt, 1); check("sim_pend_left", pending, 4'b0100);
        nxt(); check("sim_serv1", in_service, 1);
        rsi = 1'b1; nxt(); rsi = 1'b0;
        nxt(); check("sim_id2", irq_id, 2); check("sim_int2", interrupt, 1);

        // Stall for three cycles while firing.
        hi = 1;
        stall = 1'b1;
        repeat (3) begin nxt(); hi += int'(interrupt); end
        stall = 1'b0;
        nxt(); hi += int'(interrupt);
        check("stall_int_cycles", hi, 4);
        check("stall_serv", in_service, 1);
        check("stall_pending", pending, 0);
        nxt(); check("stall_single_entry", interrupt, 0);

        // rti with rsi ends service; rti in IDLE does nothing.
        rti = 1'b1; rsi = 1'b1; nxt(); rti = 1'b0; rsi = 1'b0;
        check("both_idle", in_service, 0);
        rti = 1'b1; nxt(); rti = 1'b0;
        check("rti_idle_int", interrupt, 0); check("rti_idle_serv", in_service, 0);

        // Masked request persists, then dispatches once unmasked.
        irq_src = '0; irq_mask = '0; nxt();
        irq_src = 4'b1000; nxt(); nxt(); nxt();
        check("mask_hold_pend", pending, 4'b1000); check("mask_hold_int", interrupt, 0);
        irq_mask = 4'hF; nxt();
        check("unmask_int", interrupt, 1); check("unmask_id", irq_id, 3);

        // Reset mid-SERVICE discards pending; held sources re-register after release.
        nxt(); irq_src = 4'b1100;
        nxt(); check("mid_pending", pending, 4'b0100); check("mid_serv", in_service, 1);
        rst_n = 1'b0; nxt();
        check("abort_pending", pending, 0); check("abort_serv", in_service, 0);
        check("abort_int", interrupt, 0); check("abort_id", irq_id, 0);
        rst_n = 1'b1; nxt();
        check("held_edge", pending, 4'b1100);

`ifdef IRQ_TIMEOUT_EN
        // Watchdog: no rti/rsi -> exactly TO SERVICE cycles then sticky error.
        rst_n = 1'b0; irq_src = '0; nxt();
        rst_n = 1'b1; nxt();
        irq_src = 4'b0001;
        n = 0;
        while (!in_service && n < 20) begin nxt(); n++; end
        check("to_reached_service", in_service, 1);
        n = 1;
        while (n < 100) begin
            nxt();
            if (!in_service) break;
            n++;
        end
        check("to_cycles", n, TO);
        check("to_err", timeout_err, 1);
        repeat (3) nxt();
        check("to_sticky", timeout_err, 1);
`endif

        // Randomized traffic; the compare process checks every cycle.
        for (int k = 0; k < 4000; k++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            end
            if ($urandom_range(0, 31) == 0) irq_mask = N'($urandom);
            stall = ($urandom_range(0, 9) < 3);
            rti   = ($urandom_range(0, 9) == 0);
            rsi   = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            nxt();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
